// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with transmit FIFO and per-frame format control
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [7:0]             data,
    input  logic [DIV_W-1:0]       k,
    input  logic                   eight,
    input  logic                   parity_en,
    input  logic                   ohel,
    input  logic                   two_stop,
    input  logic                   clr_ovf,
    output logic                   Tx,
    output logic                   TxRDY,
    output logic                   busy,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full_r;
    logic             empty_r;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_next;
    logic [7:0]       head;

    logic [DIV_W-1:0] timer;
    logic [DIV_W-1:0] f_k;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             f_eight;
    logic             f_par_en;
    logic             f_par_bit;
    logic             f_two;
    logic             bit_end;
    logic             last_data;
    logic             last_stop;

    assign head      = mem[rd_ptr];
    assign bit_end   = (timer == f_k);
    assign last_data = (bit_cnt == (f_eight ? 3'd7 : 3'd6));
    assign last_stop = (bit_cnt == {2'b00, f_two});

    // A new frame starts from IDLE or straight out of the final stop bit so frames run back-to-back
    assign pop  = ~empty_r & ((state == IDLE) | ((state == STOP) & bit_end & last_stop));
    assign push = load & ~full_r;

    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign TxRDY = ~full_r;
    assign empty = empty_r;

    // FIFO storage; contents need no reset because occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, occupancy, registered flags and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_next;
            full_r  <= (count_next == FULL_CNT);
            empty_r <= (count_next == '0);
            // A dropped write wins over a same-cycle clear so no drop goes unreported
            if (load & full_r) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer: bit timing, serialisation and registered line/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            f_k       <= '0;
            f_eight   <= 1'b0;
            f_par_en  <= 1'b0;
            f_par_bit <= 1'b0;
            f_two     <= 1'b0;
            Tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    Tx   <= 1'b1;
                    busy <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        Tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (last_data) begin
                            bit_cnt <= '0;
                            if (f_par_en) begin
                                Tx    <= f_par_bit;
                                state <= PARITY;
                            end else begin
                                Tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            Tx      <= shreg[1];
                        end
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        Tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (last_stop) begin
                            done  <= 1'b1;
                            Tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Frame format and divisor are captured here so mid-frame input changes cannot disturb the line
            if (pop) begin
                shreg     <= head;
                f_k       <= k;
                f_eight   <= eight;
                f_par_en  <= parity_en;
                f_par_bit <= (eight ? ^head : ^head[6:0]) ^ ohel;
                f_two     <= two_stop;
                timer     <= '0;
                bit_cnt   <= '0;
                Tx        <= 1'b0;
                busy      <= 1'b1;
                state     <= START;
            end
        end
    end

endmodule
